stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
- Time-keeping core of the stopwatch, directly downstream of the clock divider.
- Consumes single-cycle 1 Hz and adjust-rate tick pulses derived from the divider counters, plus debounced button pulses.
- Maintains MM:SS as four registered BCD digits for the 7-segment display mux.
- Supports run/pause, synchronous clear, and a manual adjust mode that advances minutes or seconds independently.

Parameters:
- MIN_MAX, 59, highest minute value before wrap; legal 1..99.
- SEC_MAX, 59, highest second value before wrap; legal 1..59.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  asynchronous, active-low reset; asserted when 0.
- tick_1hz  input  1  one-cycle pulse, once per second.
- tick_adj  input  1  one-cycle pulse at adjust rate (2 Hz or 5 Hz).
- pause_btn  input  1  one-cycle debounced pulse; toggles run/pause.
- clear_btn  input  1  one-cycle debounced pulse; zeroes the time.
- adj  input  1  level; 1 = adjust mode.
- sel  input  1  level; in adjust mode, 0 = minutes, 1 = seconds.
- min_tens  output  4  BCD minutes tens digit.
- min_ones  output  4  BCD minutes ones digit.
- sec_tens  output  4  BCD seconds tens digit.
- sec_ones  output  4  BCD seconds ones digit.
- running  output  1  1 while in RUN.
- wrap  output  1  one-cycle pulse on MM:SS rollover.

Behaviour:
- Reset (rst=0, async): all digits 0, running=0, wrap=0, state=PAUSED.
- All outputs are registered. A tick sampled high on edge N is reflected in the outputs after edge N.
- States:
  - RUN: tick_1hz advances time by one second.
  - PAUSED: time is held.
  - ADJUST: tick_adj advances the field selected by sel.
- Transitions, highest priority first:
  - adj=1 forces ADJUST from any state.
  - adj falling: ADJUST -> PAUSED.
  - pause_btn: RUN <-> PAUSED; ignored in ADJUST.
- Priority within a cycle:
  - clear_btn first: digits -> 0; state unchanged except RUN -> PAUSED; all ticks in that cycle are dropped.
  - Then mode change.
  - Then counting.
- RUN with pause_btn and tick_1hz in the same cycle: the tick is counted and the state becomes PAUSED.
- Entering ADJUST from RUN on the same cycle as tick_1hz: the tick is dropped.
- Counting in RUN:
  - sec_ones 9 -> 0 carries into sec_tens.
  - Seconds == SEC_MAX -> 00 and increments minutes.
  - min_ones 9 -> 0 carries into min_tens.
  - Minutes == MIN_MAX with seconds == SEC_MAX -> 00:00; wrap pulses for 1 cycle; state stays RUN.
- Adjust:
  - sel=0: minutes +1; MIN_MAX -> 00; no effect on seconds.
  - sel=1: seconds +1; SEC_MAX -> 00; no carry into minutes.
  - wrap is never asserted in ADJUST.
- sel changes mid-ADJUST take effect at the next tick_adj.
- tick_1hz is ignored in PAUSED and ADJUST. tick_adj is ignored outside ADJUST.
- Digits never hold non-BCD values, e.g. 09 -> 10, never 0A.
- Reset mid-count clears immediately, regardless of clk.

Optional Feature:
- Macro: STOPWATCH_SATURATE_EN.
- Defined: on reaching MIN_MAX:SEC_MAX in RUN, the next tick_1hz is dropped. Time holds at the maximum, the state becomes PAUSED (running=0), and wrap pulses once. Further pause_btn presses return to RUN, but time stays saturated until clear_btn or adjust.
- Undefined: wraps to 00:00 as described in Behaviour.

Test Plan:
- Release rst, pause_btn, 125 tick_1hz pulses -> digits 0,2,0,5 (02:05); running=1.
- Set 59:58 via adjust, exit adj, pause_btn, 2 ticks -> 00:00 with one wrap pulse. With STOPWATCH_SATURATE_EN: 59:59, running=0.
- adj=1, sel=1, 61 tick_adj pulses from 00:00 -> 00:01, minutes unchanged. Then sel=0, 3 pulses -> 03:01.
- RUN at 00:10, pause_btn and tick_1hz in the same cycle -> 00:11, running=0. 5 further ticks -> still 00:11.
- RUN at 12:34, clear_btn and tick_1hz in the same cycle -> 00:00, running=0.
- RUN at 07:07, assert rst=0 between clock edges -> digits 0 and running=0 immediately. Deassert -> state PAUSED.

Source files
------------

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: four BCD digits with run/pause, clear and manual adjust.
// Optional macro STOPWATCH_SATURATE_EN holds time at MIN_MAX:SEC_MAX instead of wrapping.
module stopwatch_counter #(
   parameter int MIN_MAX = 59,
   parameter int SEC_MAX = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       tick_adj,
   input  logic       pause_btn,
   input  logic       clear_btn,
   input  logic       adj,
   input  logic       sel,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       wrap
);

   typedef enum logic [1:0] {PAUSED, RUN, ADJUST} state_t;

   localparam logic [7:0] MIN_LIM = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
   localparam logic [7:0] SEC_LIM = {4'(SEC_MAX / 10), 4'(SEC_MAX % 10)};

   state_t     state, state_n;
   logic [7:0] min_q, min_n;
   logic [7:0] sec_q, sec_n;
   logic       wrap_n;
   logic       at_max;
`ifdef STOPWATCH_SATURATE_EN
   logic       sat, sat_n;
`endif

   // Two-digit BCD increment that rolls over to 00 after the limit.
   function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] lim);
      if (val == lim)
         return 8'h00;
      else if (val[3:0] == 4'd9)
         return {val[7:4] + 4'd1, 4'd0};
      else
         return {val[7:4], val[3:0] + 4'd1};
   endfunction

   assign at_max = (min_q == MIN_LIM) && (sec_q == SEC_LIM);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_n = state;
      min_n   = min_q;
      sec_n   = sec_q;
      wrap_n  = 1'b0;
`ifdef STOPWATCH_SATURATE_EN
      sat_n   = sat;
`endif
      if (clear_btn) begin
         min_n = 8'h00;
         sec_n = 8'h00;
         if (state == RUN)
            state_n = PAUSED;
`ifdef STOPWATCH_SATURATE_EN
         sat_n = 1'b0;
`endif
      end else begin
         if (adj)
            state_n = ADJUST;
         else if (state == ADJUST)
            state_n = PAUSED;
         else if (pause_btn)
            state_n = (state == RUN) ? PAUSED : RUN;

         // Ticks count only when the current state is still in force this cycle.
         if (state == RUN && !adj && tick_1hz) begin
`ifdef STOPWATCH_SATURATE_EN
            if (at_max) begin
               if (!sat) begin
                  wrap_n  = 1'b1;
                  sat_n   = 1'b1;
                  state_n = PAUSED;
               end
            end else if (sec_q == SEC_LIM) begin
               sec_n = 8'h00;
               min_n = bcd_inc(min_q, MIN_LIM);
            end else begin
               sec_n = bcd_inc(sec_q, SEC_LIM);
            end
`else
            if (sec_q == SEC_LIM) begin
               sec_n  = 8'h00;
               min_n  = bcd_inc(min_q, MIN_LIM);
               wrap_n = at_max;
            end else begin
               sec_n = bcd_inc(sec_q, SEC_LIM);
            end
`endif
         end

         if (state == ADJUST && adj && tick_adj) begin
            if (sel)
               sec_n = bcd_inc(sec_q, SEC_LIM);
            else
               min_n = bcd_inc(min_q, MIN_LIM);
         end
`ifdef STOPWATCH_SATURATE_EN
         if (state_n == ADJUST)
            sat_n = 1'b0;
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= PAUSED;
         min_q   <= 8'h00;
         sec_q   <= 8'h00;
         running <= 1'b0;
         wrap    <= 1'b0;
`ifdef STOPWATCH_SATURATE_EN
         sat     <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         min_q   <= min_n;
         sec_q   <= sec_n;
         running <= (state_n == RUN);
         wrap    <= wrap_n;
`ifdef STOPWATCH_SATURATE_EN
         sat     <= sat_n;
`endif
      end
   end

   assign min_tens = min_q[7:4];
   assign min_ones = min_q[3:0];
   assign sec_tens = sec_q[7:4];
   assign sec_ones = sec_q[3:0];

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter; expectations follow STOPWATCH_SATURATE_EN when defined.
module tb_stopwatch_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_1hz = 1'b0, tick_adj = 1'b0;
   logic       pause_btn = 1'b0, clear_btn = 1'b0;
   logic       adj = 1'b0, sel = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       running, wrap;
   logic [15:0] digits;
   int         checks = 0;
   int         passed = 0;
   int         wrap_cnt = 0;
   int         wrap_base;

   stopwatch_counter dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
      .pause_btn(pause_btn), .clear_btn(clear_btn), .adj(adj), .sel(sel),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .running(running), .wrap(wrap)
   );

   always #5 clk = ~clk;
   assign digits = {min_tens, min_ones, sec_tens, sec_ones};

   always @(negedge clk)
      if (rst && wrap) wrap_cnt++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      {tick_1hz, tick_adj, pause_btn, clear_btn, adj, sel} = '0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic tick(int n);
      for (int i = 0; i < n; i++) begin
         tick_1hz = 1'b1;
         step();
         tick_1hz = 1'b0;
      end
   endtask

   task automatic adj_ticks(int n);
      for (int i = 0; i < n; i++) begin
         tick_adj = 1'b1;
         step();
         tick_adj = 1'b0;
      end
   endtask

   task automatic press_pause();
      pause_btn = 1'b1;
      step();
      pause_btn = 1'b0;
   endtask

   // Reset, then set mm:ss through adjust mode and leave it paused.
   task automatic set_time(int mm, int ss);
      do_reset();
      adj = 1'b1;
      sel = 1'b0;
      step();
      adj_ticks(mm);
      sel = 1'b1;
      adj_ticks(ss);
      adj = 1'b0;
      step();
   endtask

   task automatic check_digits(string name, logic [15:0] exp);
      checks++;
      if (digits !== exp) $display("FAIL %s: digits got %h expected %h", name, digits, exp);
      else passed++;
   endtask

   task automatic check_running(string name, logic exp);
      checks++;
      if (running !== exp) $display("FAIL %s: running got %b expected %b", name, running, exp);
      else passed++;
   endtask

   task automatic check_wraps(string name, int exp);
      checks++;
      if (wrap_cnt - wrap_base !== exp)
         $display("FAIL %s: wrap pulses got %0d expected %0d", name, wrap_cnt - wrap_base, exp);
      else passed++;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      check_digits("reset_digits", 16'h0000);
      check_running("reset_running", 1'b0);
      checks++;
      if (wrap !== 1'b0) $display("FAIL reset_wrap: got %b expected 0", wrap);
      else passed++;
   endtask

   task automatic test_run_count();
      do_reset();
      press_pause();
      check_running("run_start", 1'b1);
      tick(10);
      check_digits("run_09_to_10", 16'h0010);
      tick(115);
      check_digits("run_125", 16'h0205);
      check_running("run_125_running", 1'b1);
   endtask

   task automatic test_wrap();
      set_time(59, 58);
      check_digits("wrap_set", 16'h5958);
      check_running("wrap_set_paused", 1'b0);
      press_pause();
      wrap_base = wrap_cnt;
      tick(1);
      check_digits("wrap_first_tick", 16'h5959);
      tick(1);
      step();
`ifdef STOPWATCH_SATURATE_EN
      check_digits("sat_hold", 16'h5959);
      check_running("sat_paused", 1'b0);
      check_wraps("sat_wrap_once", 1);
      press_pause();
      check_running("sat_resume", 1'b1);
      tick(3);
      step();
      check_digits("sat_still_held", 16'h5959);
      check_wraps("sat_no_second_wrap", 1);
`else
      check_digits("wrap_rollover", 16'h0000);
      check_running("wrap_still_running", 1'b1);
      check_wraps("wrap_one_pulse", 1);
      tick(1);
      check_digits("wrap_after", 16'h0001);
`endif
   endtask

   task automatic test_adjust();
      do_reset();
      wrap_base = wrap_cnt;
      adj = 1'b1;
      sel = 1'b1;
      step();
      check_running("adj_running", 1'b0);
      adj_ticks(61);
      check_digits("adj_sec_61", 16'h0001);
      check_wraps("adj_no_wrap", 0);
      tick(2);
      check_digits("adj_ignores_1hz", 16'h0001);
      sel = 1'b0;
      adj_ticks(3);
      check_digits("adj_min_3", 16'h0301);
      adj = 1'b0;
      step();
      adj_ticks(2);
      check_digits("adj_exit_ignores_adj_tick", 16'h0301);
   endtask

   task automatic test_pause_tick();
      do_reset();
      press_pause();
      tick(10);
      check_digits("pt_at_10", 16'h0010);
      pause_btn = 1'b1;
      tick_1hz = 1'b1;
      step();
      {pause_btn, tick_1hz} = '0;
      check_digits("pt_same_cycle", 16'h0011);
      check_running("pt_paused", 1'b0);
      tick(5);
      check_digits("pt_held", 16'h0011);
   endtask

   task automatic test_clear();
      set_time(12, 34);
      press_pause();
      check_running("clr_run", 1'b1);
      clear_btn = 1'b1;
      tick_1hz = 1'b1;
      step();
      {clear_btn, tick_1hz} = '0;
      check_digits("clr_digits", 16'h0000);
      check_running("clr_paused", 1'b0);
   endtask

   task automatic test_adj_entry_drop();
      do_reset();
      press_pause();
      tick(3);
      adj = 1'b1;
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      check_digits("entry_tick_dropped", 16'h0003);
      check_running("entry_not_running", 1'b0);
      adj = 1'b0;
      step();
   endtask

   task automatic test_async_reset();
      set_time(7, 7);
      press_pause();
      check_running("ar_run", 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check_digits("ar_digits_now", 16'h0000);
      check_running("ar_running_now", 1'b0);
      step();
      rst = 1'b1;
      step();
      tick(2);
      check_digits("ar_paused_hold", 16'h0000);
      press_pause();
      check_running("ar_toggle_to_run", 1'b1);
   endtask

   initial begin
      test_reset();
      test_run_count();
      test_wrap();
      test_adjust();
      test_pause_tick();
      test_clear();
      test_adj_entry_drop();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
